// File: rtl/otp_burn_sequencer.sv
// Timed program / settle / verify / retry sequencer for the antifuse macro.
// Reports sticky burned/failed status and holds kill_req from burn start onward.
module otp_burn_sequencer #(
   parameter int PGM_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fuse_fire,
   input  logic       fuse_blow_req,
   input  logic       otp_sense,
   output logic       otp_pgm,
   output logic       otp_sense_en,
   output logic       kill_req,
   output logic       busy,
   output logic       burn_done,
   output logic       burn_fail,
   output logic [1:0] attempt_count
);

   localparam int CNT_MAX = (PGM_CYCLES > SETTLE_CYCLES) ? PGM_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] PGM_LAST    = CNT_W'(PGM_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0]       MAX_ATT     = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      BOOT_SENSE,
      IDLE,
      PGM,
      SETTLE,
      VERIFY,
      DONE,
      FAIL
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       att_nxt;
   logic             pending, pending_nxt;
   logic             trigger;

   assign trigger = fuse_fire | fuse_blow_req;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= BOOT_SENSE;
         cnt           <= '0;
         attempt_count <= '0;
         pending       <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         attempt_count <= att_nxt;
         pending       <= pending_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt + CNT_W'(1);
      att_nxt      = attempt_count;
      pending_nxt  = pending;
      otp_pgm      = 1'b0;
      otp_sense_en = 1'b0;
      kill_req     = 1'b0;
      busy         = 1'b0;
      burn_done    = 1'b0;
      burn_fail    = 1'b0;

      case (state)
         BOOT_SENSE: begin
            otp_sense_en = 1'b1;
            busy         = 1'b1;
            if (trigger) pending_nxt = 1'b1;
            if (cnt == SETTLE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = otp_sense ? DONE : IDLE;
            end
         end
         IDLE: begin
            cnt_nxt = '0;
            // A request latched during boot sense starts the burn here.
            if (trigger || pending) begin
               state_nxt   = PGM;
               att_nxt     = 2'd1;
               pending_nxt = 1'b0;
            end
         end
         PGM: begin
            otp_pgm  = 1'b1;
            kill_req = 1'b1;
            busy     = 1'b1;
            if (cnt == PGM_LAST) begin
               cnt_nxt   = '0;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            otp_sense_en = 1'b1;
            kill_req     = 1'b1;
            busy         = 1'b1;
            if (cnt == SETTLE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = VERIFY;
            end
         end
         VERIFY: begin
            otp_sense_en = 1'b1;
            kill_req     = 1'b1;
            busy         = 1'b1;
            cnt_nxt      = '0;
            if (otp_sense) begin
               state_nxt = DONE;
            end else if (attempt_count < MAX_ATT) begin
               state_nxt = PGM;
               att_nxt   = attempt_count + 2'd1;
            end else begin
               state_nxt = FAIL;
            end
         end
         DONE: begin
            kill_req  = 1'b1;
            burn_done = 1'b1;
            cnt_nxt   = '0;
         end
         FAIL: begin
            kill_req  = 1'b1;
            burn_fail = 1'b1;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = BOOT_SENSE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: doc/otp_burn_sequencer.md
Name: otp_burn_sequencer

Overview:
- Downstream of the single-read collapse register.
- Consumes that register's one-cycle fuse-fire pulse and any external tamper request.
- Runs a timed program / settle / verify / retry sequence on the one-time-programmable antifuse macro, then reports sticky burned or failed status.
- Its kill request output feeds back to the collapse register's fuse-blow input, so the pad stays disabled for the whole burn and afterwards.

Parameters:
PGM_CYCLES, 16, width of one program pulse in clocks (≥1)
SETTLE_CYCLES, 4, sense-amp settle time before sampling (≥1), used at boot and after each pulse
MAX_RETRIES, 3, maximum program attempts (1..3)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
fuse_fire  in  1  one-cycle burn trigger from the collapse register
fuse_blow_req  in  1  external tamper/CSR burn request (level or pulse)
otp_sense  in  1  antifuse sense output, 1 = blown; valid only after settle
otp_pgm  out  1  program-voltage enable to the antifuse macro
otp_sense_en  out  1  sense-amp enable
kill_req  out  1  drive to the collapse register's fuse_blow; high from burn start onward
busy  out  1  sequence in progress
burn_done  out  1  sticky: fuse verified blown
burn_fail  out  1  sticky: retries exhausted without a blown reading
attempt_count  out  2  number of program pulses issued in this burn

Behaviour:
- Reset (sampled low at an edge):
  - State goes to BOOT_SENSE; counters, attempt_count and the pending flag clear.
  - After that edge: otp_pgm=0, kill_req=0, burn_done=0, burn_fail=0, attempt_count=0.
  - Also after that edge: otp_sense_en=1 and busy=1, because BOOT_SENSE decode applies.
  - Reset mid-sequence drops otp_pgm at that edge; the sequence restarts in BOOT_SENSE.
- All outputs are decoded from registered state and registered counters only. There is no combinational path from any input to any output.
- States and transitions:
  - BOOT_SENSE:
    - otp_sense_en=1 for SETTLE_CYCLES cycles.
    - On the last cycle, sample otp_sense: 1 → DONE with attempt_count=0; 0 → IDLE.
    - fuse_fire or fuse_blow_req seen here sets the pending flag.
  - IDLE:
    - All outputs 0.
    - fuse_fire | fuse_blow_req | pending → PGM, attempt_count=1, pending cleared.
    - Simultaneous triggers produce one burn.
  - PGM:
    - otp_pgm=1 for exactly PGM_CYCLES cycles, then → SETTLE.
  - SETTLE:
    - otp_pgm=0, otp_sense_en=1 for SETTLE_CYCLES cycles, then → VERIFY.
  - VERIFY (1 cycle):
    - otp_sense_en=1; sample otp_sense.
    - otp_sense=1 → DONE.
    - otp_sense=0 and attempt_count<MAX_RETRIES → PGM, attempt_count+1.
    - Otherwise → FAIL.
  - DONE: burn_done=1. Terminal until reset.
  - FAIL: burn_fail=1. Terminal until reset.
- Output decode:
  - busy = BOOT_SENSE|PGM|SETTLE|VERIFY.
  - kill_req = PGM|SETTLE|VERIFY|DONE|FAIL. It is never asserted in BOOT_SENSE or IDLE.
- Latency:
  - Trigger sampled in IDLE at edge E0: otp_pgm is high in the PGM_CYCLES cycles after E0.
  - Each attempt lasts PGM_CYCLES+SETTLE_CYCLES+1 cycles.
  - burn_done or burn_fail rises N·(PGM_CYCLES+SETTLE_CYCLES+1) cycles after E0, where N is the final attempt_count.
- Triggers in PGM, SETTLE, VERIFY, DONE or FAIL are ignored and not queued.
- otp_pgm is never asserted in the same cycle as otp_sense_en.
- otp_sense is ignored outside VERIFY and the last BOOT_SENSE cycle.
- Counter width is sized to max(PGM_CYCLES, SETTLE_CYCLES); no wrap is possible.

Test Plan (defaults PGM=16, SETTLE=4, MAX=3):
1. Release reset, otp_sense=0 → otp_sense_en high 4 cycles, then IDLE; busy falls; burn_done=burn_fail=kill_req=0; attempt_count=0.
2. One-cycle fuse_fire in IDLE; sense model returns 1 after the first pulse → otp_pgm high exactly 16 cycles, sense_en 5 cycles, burn_done at cycle 21 after trigger; attempt_count=1; kill_req high from cycle 1 and stays high.
3. otp_sense stuck 0, fuse_fire → three 16-cycle pulses separated by 5-cycle sense windows; burn_fail at cycle 63; attempt_count=3; no further otp_pgm.
4. Reset release with otp_sense=1 → DONE after 4 cycles; otp_pgm never asserted; attempt_count=0; kill_req=1; later fuse_fire ignored.
5. Trigger handling, each sub-case checked separately:
   - fuse_blow_req pulse during BOOT_SENSE → burn starts on the edge after IDLE entry.
   - fuse_fire and fuse_blow_req together in IDLE → exactly one 16-cycle pulse.
   - fuse_fire during PGM → no extra attempt.
6. reset low at cycle 8 of PGM → otp_pgm=0 after that edge; kill_req=0; attempt_count=0; BOOT_SENSE re-runs and the sequence returns to IDLE with otp_sense=0.
